hook_line_renderer: RTL

- Multi-hook successor to the single-hook fishing-line/hook pixel colouriser.
- Draws N_HOOKS vertical fishing lines and hook sprites into the VGA pixel stream.
- Owns a per-hook cut/retract animation state machine, frame-latched scaled positions, and a 2-stage registered pixel pipeline.
- Sits between game logic (positions, cut/restore events) and the background/sprite mixer, which consumes `background` as a transparency flag.

---
 rtl/hook_line_pkg.sv | 35 +++
 rtl/hook_channel.sv | 138 +++++++++++++
 rtl/hook_line_renderer.sv | 83 ++++++++
 3 files changed

// File: rtl/hook_line_pkg.sv
// Shared types and sprite tables for the multi-hook line/hook renderer.
package hook_line_pkg;

   typedef enum logic [1:0] {
      ATTACHED = 2'b00,
      CUT      = 2'b01,
      RETRACT  = 2'b10,
      HIDDEN   = 2'b11
   } line_state_e;

   typedef logic [11:0] rgb444_t;

   localparam int unsigned SPRITE_W = 7;

   // First sprite row drawn in column dx; column 7 is outside the sprite.
   function automatic logic [3:0] sprite_lo(input logic [2:0] dx);
      if (dx == 3'd7) return 4'd15;
      return 4'(dx);
   endfunction

   // Last sprite row drawn in column dx.
   function automatic logic [3:0] sprite_hi(input logic [2:0] dx);
      case (dx)
         3'd0:    return 4'd9;
         3'd1:    return 4'd8;
         3'd2:    return 4'd8;
         3'd3:    return 4'd7;
         3'd4:    return 4'd7;
         3'd5:    return 4'd6;
         3'd6:    return 4'd6;
         default: return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/hook_channel.sv
// One hook/line channel: frame-latched position, cut/retract FSM and stage-1 hit flags.
// Optional HOOK_BLINK_EN: hook blinks while the line is cut.
module hook_channel
   import hook_line_pkg::*;
#(
   parameter int unsigned IDX          = 0,
   parameter int unsigned POS_W        = 14,
   parameter int unsigned CNT_W        = 10,
   parameter int unsigned SCALE        = 10,
   parameter int unsigned LINE_TOP     = 62,
   parameter int unsigned ANCHOR_X0    = 279,
   parameter int unsigned ANCHOR_PITCH = 40,
   parameter int unsigned HOLD_FRAMES  = 30,
   parameter int unsigned RETRACT_STEP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             valid,
   input  logic [CNT_W-1:0] h_cnt,
   input  logic [CNT_W-1:0] v_cnt,
   input  logic [POS_W-1:0] h_position,
   input  logic [POS_W-1:0] v_position,
   input  logic             cut,
   input  logic             restore,
   output logic             line_hit,
   output logic             hook_hit,
   output line_state_e      state
);

   localparam int unsigned ANCHOR_X = ANCHOR_X0 + IDX * ANCHOR_PITCH;
   localparam int unsigned HOLD_W   = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
   localparam int unsigned DW       = CNT_W + 1;

   logic [CNT_W-1:0]  hx, hy, end_v;
   logic [HOLD_W-1:0] hold;
   logic              cut_q;
   logic              cut_edge_c;
   logic [CNT_W-1:0]  line_end_c;
   logic [DW-1:0]     dx_c, dy_c;
   logic              draw_hook_c;
   logic              in_sprite_c;
   logic              line_hit_c;

   function automatic logic [CNT_W-1:0] scale_sat(input logic [POS_W-1:0] p);
      logic [POS_W-1:0] q;
      q = p / POS_W'(SCALE);
      if (32'(q) > CNT_MAX) return CNT_W'(CNT_MAX);
      return CNT_W'(q);
   endfunction

   assign cut_edge_c = cut & ~cut_q;

   // Position latch, edge detector and cut/retract FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ATTACHED;
         hold  <= '0;
         end_v <= CNT_W'(LINE_TOP);
         hx    <= '0;
         hy    <= '0;
         cut_q <= 1'b0;
      end else begin
         cut_q <= cut;
         if (frame_start) begin
            hx <= scale_sat(h_position);
            hy <= scale_sat(v_position);
         end
         if (restore && state != ATTACHED) begin
            state <= ATTACHED;
            end_v <= CNT_W'(LINE_TOP);
         end else begin
            case (state)
               ATTACHED: if (cut_edge_c) begin
                  end_v <= hy;
                  hold  <= '0;
                  state <= CUT;
               end
               CUT: if (frame_start) begin
                  if (hold == HOLD_W'(HOLD_FRAMES - 1)) state <= RETRACT;
                  else                                  hold  <= hold + HOLD_W'(1);
               end
               RETRACT: if (frame_start) begin
                  if (end_v <= CNT_W'(LINE_TOP + RETRACT_STEP)) begin
                     end_v <= CNT_W'(LINE_TOP);
                     state <= HIDDEN;
                  end else begin
                     end_v <= end_v - CNT_W'(RETRACT_STEP);
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef HOOK_BLINK_EN
   logic [3:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)           frame_cnt <= '0;
      else if (frame_start) frame_cnt <= frame_cnt + 4'd1;
   end

   assign draw_hook_c = (state == ATTACHED) || (state == CUT && frame_cnt[3]);
`else
   assign draw_hook_c = (state == ATTACHED);
`endif

   assign line_end_c = (state == ATTACHED) ? hy : end_v;

   // Offsets carry a sign bit so pixels left of / above the hook never alias into it.
   assign dx_c = {1'b0, h_cnt} - {1'b0, hx};
   assign dy_c = {1'b0, v_cnt} - {1'b0, hy};

   assign in_sprite_c = !dx_c[CNT_W] && !dy_c[CNT_W]
                     && (dx_c < DW'(SPRITE_W))
                     && (dy_c >= DW'(sprite_lo(dx_c[2:0])))
                     && (dy_c <= DW'(sprite_hi(dx_c[2:0])));

   assign line_hit_c = valid && (state != HIDDEN)
                    && (h_cnt == CNT_W'(ANCHOR_X))
                    && (v_cnt >= CNT_W'(LINE_TOP))
                    && (v_cnt <= line_end_c);

   // Stage 1 of the pixel pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_hit <= 1'b0;
         hook_hit <= 1'b0;
      end else begin
         line_hit <= line_hit_c;
         hook_hit <= valid && draw_hook_c && in_sprite_c;
      end
   end

endmodule

// File: rtl/hook_line_renderer.sv
// Multi-hook fishing line/hook colouriser feeding the background/sprite mixer.
// Optional HOOK_BLINK_EN: cut hooks blink before retracting.
module hook_line_renderer
   import hook_line_pkg::*;
#(
   parameter int unsigned N_HOOKS      = 2,
   parameter int unsigned POS_W        = 14,
   parameter int unsigned CNT_W        = 10,
   parameter int unsigned SCALE        = 10,
   parameter int unsigned LINE_TOP     = 62,
   parameter int unsigned ANCHOR_X0    = 279,
   parameter int unsigned ANCHOR_PITCH = 40,
   parameter int unsigned HOLD_FRAMES  = 30,
   parameter int unsigned RETRACT_STEP = 4,
   parameter rgb444_t     HOOK_COLOR   = 12'hfff,
   parameter rgb444_t     LINE_COLOR   = 12'h000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     frame_start,
   input  logic                     valid,
   input  logic [CNT_W-1:0]         h_cnt,
   input  logic [CNT_W-1:0]         v_cnt,
   input  logic [N_HOOKS*POS_W-1:0] h_position,
   input  logic [N_HOOKS*POS_W-1:0] v_position,
   input  logic [N_HOOKS-1:0]       cut,
   input  logic [N_HOOKS-1:0]       restore,
   output rgb444_t                  vga,
   output logic                     background,
   output logic [2*N_HOOKS-1:0]     line_state
);

   logic [N_HOOKS-1:0] line_hits;
   logic [N_HOOKS-1:0] hook_hits;
   line_state_e        states [N_HOOKS];

   for (genvar i = 0; i < N_HOOKS; i++) begin : g_ch
      hook_channel #(
         .IDX          (i),
         .POS_W        (POS_W),
         .CNT_W        (CNT_W),
         .SCALE        (SCALE),
         .LINE_TOP     (LINE_TOP),
         .ANCHOR_X0    (ANCHOR_X0),
         .ANCHOR_PITCH (ANCHOR_PITCH),
         .HOLD_FRAMES  (HOLD_FRAMES),
         .RETRACT_STEP (RETRACT_STEP)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .frame_start (frame_start),
         .valid       (valid),
         .h_cnt       (h_cnt),
         .v_cnt       (v_cnt),
         .h_position  (h_position[i*POS_W +: POS_W]),
         .v_position  (v_position[i*POS_W +: POS_W]),
         .cut         (cut[i]),
         .restore     (restore[i]),
         .line_hit    (line_hits[i]),
         .hook_hit    (hook_hits[i]),
         .state       (states[i])
      );
      assign line_state[2*i +: 2] = states[i];
   end

   // Stage 2: lines over hooks; all hooks of a class share one colour.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vga        <= 12'h000;
         background <= 1'b1;
      end else if (|line_hits) begin
         vga        <= LINE_COLOR;
         background <= 1'b0;
      end else if (|hook_hits) begin
         vga        <= HOOK_COLOR;
         background <= 1'b0;
      end else begin
         vga        <= 12'h000;
         background <= 1'b1;
      end
   end

endmodule
